// File: rtl/spi_minion_pkg.sv
// Shared types and constants for the SPI minion front end.
package spi_minion_pkg;

   localparam int SYNC_DEPTH = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Counter must reach BIT_WIDTH+1 so over-long frames stay distinguishable.
   function automatic int cnt_width(input int bit_width);
      return $clog2(bit_width + 2);
   endfunction

endpackage

// File: rtl/spi_minion_frontend_if.sv
// Stream side of the SPI minion: received frames out, transmit words in.
interface spi_minion_frontend_if #(
   parameter int BIT_WIDTH = 24
);
   logic [BIT_WIDTH-1:0] recv_msg;
   logic                 recv_val;
   logic                 recv_rdy;
   logic [BIT_WIDTH-1:0] send_msg;
   logic                 send_val;
   logic                 send_rdy;

   modport master (
      output recv_msg, recv_val, send_rdy,
      input  recv_rdy, send_msg, send_val
   );

   modport slave (
      input  recv_msg, recv_val, send_rdy,
      output recv_rdy, send_msg, send_val
   );
endinterface

// File: rtl/spi_minion_sync_edge.sv
// Two-flop synchroniser for one SPI pin plus a history flop for edge pulses.
module spi_minion_sync_edge
   import spi_minion_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  hist_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], pin};
         hist_q <= sync_q[SYNC_DEPTH-1];
      end
   end

   assign level = sync_q[SYNC_DEPTH-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_minion_frontend.sv
// SPI mode-0 minion oversampled by clk, bridged to a valid/ready stream.
// Optional buffered-frame parity output enabled by SPI_MINION_FRONTEND_PARITY_EN.
module spi_minion_frontend
   import spi_minion_pkg::*;
#(
   parameter int BIT_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic                  sclk,
   input  logic                  mosi,
   output logic                  miso,
   spi_minion_frontend_if.master bus,
   output logic                  overflow,
   output logic                  parity
);

   localparam int             CW       = cnt_width(BIT_WIDTH);
   localparam logic [CW-1:0]  CNT_FULL = CW'(BIT_WIDTH);
   localparam logic [CW-1:0]  CNT_SAT  = CW'(BIT_WIDTH + 1);

   logic cs_lvl, cs_rise, cs_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

   spi_minion_sync_edge u_cs (
      .clk(clk), .reset(reset), .pin(cs),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
   );
   spi_minion_sync_edge u_sclk (
      .clk(clk), .reset(reset), .pin(sclk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_minion_sync_edge u_mosi (
      .clk(clk), .reset(reset), .pin(mosi),
      .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q;
   logic [BIT_WIDTH-1:0] rx_q, tx_q, buf_q;
   logic                 val_q, ovf_q;
   logic                 start, send_rdy, frame_done, load, drain;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      send_rdy   = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d  = SHIFT;
               start    = 1'b1;
               send_rdy = bus.send_val;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_d    = IDLE;
               frame_done = (cnt_q == CNT_FULL);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A full buffer only takes a new frame if it is being drained this cycle.
   assign load  = frame_done && (!val_q || bus.recv_rdy);
   assign drain = val_q && bus.recv_rdy && !load;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         rx_q  <= '0;
         tx_q  <= '0;
      end else if (start) begin
         cnt_q <= '0;
         tx_q  <= bus.send_val ? bus.send_msg : '0;
      end else if (state_q == SHIFT) begin
         if (sclk_rise) begin
            rx_q <= {rx_q[BIT_WIDTH-2:0], mosi_lvl};
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
         end
         if (sclk_fall) tx_q <= {tx_q[BIT_WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_q <= '0;
         val_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (load) begin
            buf_q <= rx_q;
            val_q <= 1'b1;
         end else if (drain) begin
            val_q <= 1'b0;
         end
         if (frame_done && !load) ovf_q <= 1'b1;
      end
   end

`ifdef SPI_MINION_FRONTEND_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     par_q <= 1'b0;
      else if (load)  par_q <= ^rx_q;
      else if (drain) par_q <= 1'b0;
   end

   assign parity = par_q;
`else
   assign parity = 1'b0;
`endif

   assign miso         = (state_q == SHIFT) & tx_q[BIT_WIDTH-1];
   assign bus.send_rdy = send_rdy;
   assign bus.recv_msg = buf_q;
   assign bus.recv_val = val_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_spi_minion_frontend.sv
// Directed and randomized frames against a frame-level model of the minion.
module tb_spi_minion_frontend;

   localparam int BW = 8;
   localparam int H  = 6;
`ifdef SPI_MINION_FRONTEND_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b0, cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
   logic miso, overflow, parity;

   spi_minion_frontend_if #(.BIT_WIDTH(BW)) bus ();

   spi_minion_frontend #(.BIT_WIDTH(BW)) dut (
      .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
      .miso(miso), .bus(bus.master), .overflow(overflow), .parity(parity)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, n_fail = 0;

   // observed stream activity
   int          acc_cnt = 0, srdy_cnt = 0, rv_run = 0, rv_last_run = 0;
   logic [BW-1:0] acc_msg = '0;
   logic          acc_par = 1'b0;

   always @(negedge clk) begin
      if (bus.recv_val && bus.recv_rdy) begin
         acc_cnt++;
         acc_msg = bus.recv_msg;
         acc_par = parity;
      end
      if (bus.send_rdy) srdy_cnt++;
      if (bus.recv_val) rv_run++;
      else begin
         if (rv_run != 0) rv_last_run = rv_run;
         rv_run = 0;
      end
   end

   // reference model state
   logic          m_val = 1'b0, m_ovf = 1'b0;
   logic [BW-1:0] m_msg = '0, exp_last = '0;
   int            exp_acc = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_miso(input logic sv, input logic [BW-1:0] sw, input int nbits);
      logic [31:0] r = '0;
      for (int i = 0; i < nbits; i++)
         r = {r[30:0], (sv && i < BW) ? sw[BW-1-i] : 1'b0};
      return r;
   endfunction

   task automatic set_rdy(input logic r);
      bus.recv_rdy = r;
      if (r && m_val) begin
         exp_acc++;
         exp_last = m_msg;
         m_val    = 1'b0;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " recv_val"}, bus.recv_val, 0);
      chk({tag, " recv_msg"}, bus.recv_msg, 0);
      chk({tag, " send_rdy"}, bus.send_rdy, 0);
      chk({tag, " miso"}, miso, 0);
      chk({tag, " overflow"}, overflow, 0);
      chk({tag, " parity"}, parity, 0);
   endtask

   task automatic check_state(input string tag);
      chk({tag, " recv_val"}, bus.recv_val, m_val);
      chk({tag, " overflow"}, overflow, m_ovf);
      chk({tag, " parity"}, parity, (m_val && PAR_EN) ? ^m_msg : 1'b0);
      if (m_val) chk({tag, " recv_msg"}, bus.recv_msg, m_msg);
      chk({tag, " accepted"}, acc_cnt, exp_acc);
      if (exp_acc > 0) begin
         chk({tag, " acc_msg"}, acc_msg, exp_last);
         chk({tag, " acc_parity"}, acc_par, PAR_EN ? ^exp_last : 1'b0);
      end
   endtask

   task automatic spi_bits(input logic [31:0] data, input int nbits, output logic [31:0] mbits);
      mbits = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = data[nbits-1-i];
         tick(H);
         mbits = {mbits[30:0], miso};
         sclk = 1'b1;
         tick(H);
         sclk = 1'b0;
      end
   endtask

   task automatic run_frame(input string tag, input logic [31:0] data, input int nbits,
                            input logic sv, input logic [BW-1:0] sw);
      int          s0;
      logic [31:0] mb;
      s0 = srdy_cnt;
      bus.send_val = sv;
      bus.send_msg = sw;
      cs = 1'b0;
      tick(8);
      spi_bits(data, nbits, mb);
      tick(H);
      cs = 1'b1;
      tick(10);
      bus.send_val = 1'b0;
      chk({tag, " miso_bits"}, mb, exp_miso(sv, sw, nbits));
      chk({tag, " send_rdy_pulses"}, srdy_cnt - s0, sv ? 1 : 0);
      if (nbits == BW) begin
         if (m_val) m_ovf = 1'b1;
         else if (bus.recv_rdy) begin
            exp_acc++;
            exp_last = data[BW-1:0];
         end else begin
            m_val = 1'b1;
            m_msg = data[BW-1:0];
         end
      end
      check_state(tag);
   endtask

   initial begin
      logic [31:0] mb, d;
      int          nb;
      logic        sv;
      bus.recv_rdy = 1'b0;
      bus.send_val = 1'b0;
      bus.send_msg = '0;

      tick(3);
      chk_zero("reset");
      reset = 1'b1;
      tick(6);
      set_rdy(1'b1);

      run_frame("single", 32'hA5, 8, 1'b0, 8'h00);
      chk("single recv_val_cycles", rv_last_run, 1);
      run_frame("sendrecv", 32'h81, 8, 1'b1, 8'h3C);
      run_frame("short7", 32'h2D, 7, 1'b1, 8'hC3);
      run_frame("after_short", 32'h5A, 8, 1'b0, 8'h00);
      run_frame("empty_send", 32'h99, 8, 1'b0, 8'hFF);
      run_frame("long11", 32'h6AB, 11, 1'b1, 8'hB7);

      set_rdy(1'b0);
      run_frame("bp_first", 32'h11, 8, 1'b0, 8'h00);
      run_frame("bp_second", 32'h22, 8, 1'b0, 8'h00);
      set_rdy(1'b1);
      tick(3);
      check_state("bp_drain");
      run_frame("bp_third", 32'h33, 8, 1'b0, 8'h00);

      // reset with cs held low across release
      cs = 1'b0;
      tick(8);
      spi_bits(32'hF, 4, mb);
      reset = 1'b0;
      tick(2);
      chk_zero("midreset_hold");
      m_val = 1'b0;
      m_ovf = 1'b0;
      reset = 1'b1;
      tick(4);
      chk_zero("midreset_release");
      spi_bits(32'h5, 4, mb);
      tick(10);
      check_state("cs_still_low");
      cs = 1'b1;
      tick(10);
      check_state("cs_high");
      run_frame("post_reset", 32'hF0, 8, 1'b0, 8'h00);

      for (int k = 0; k < 14; k++) begin
         set_rdy($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 4))
            0:       nb = BW - 1;
            1:       nb = BW + 1;
            default: nb = BW;
         endcase
         d  = $urandom & ((32'd1 << nb) - 1);
         sv = $urandom_range(0, 1);
         run_frame($sformatf("rand%0d", k), d, nb, sv, BW'($urandom));
      end
      set_rdy(1'b1);
      tick(3);
      check_state("final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_minion_frontend.md
# spi_minion_frontend

Synchronising SPI minion front end that converts the off-chip SPI pins (cs, sclk, mosi, miso) into a clk-domain valid/ready stream. It sits directly upstream of the tape-in interconnect. Received frames are handed forward as recv messages, and words from the interconnect are shifted back out on miso in the same frame. It oversamples the SPI pins with clk; no logic runs in the sclk domain.

## Interface
- BIT_WIDTH, default 24: frame length in bits and width of the message ports.
- clk  input  1  system clock; all state is sampled on the rising edge.
- reset  input  1  asynchronous reset, active-low.
- cs  input  1  SPI chip select, active-low, asynchronous to clk.
- sclk  input  1  SPI clock, SPI mode 0, asynchronous to clk.
- mosi  input  1  SPI data from the host, MSB first.
- miso  output  1  SPI data to the host, MSB first.
- recv_msg  output  BIT_WIDTH  received frame.
- recv_val  output  1  recv_msg is valid.
- recv_rdy  input  1  consumer accepts recv_msg.
- send_msg  input  BIT_WIDTH  word to transmit in the next frame.
- send_val  input  1  send_msg is valid.
- send_rdy  output  1  send_msg is captured this cycle.
- overflow  output  1  sticky flag: a complete frame was dropped.
- parity  output  1  parity of the buffered frame (see Configuration).

## Operation
- **Synchronisers.** cs, sclk and mosi each pass through 2 flops, then 1 history flop for edge detection.
  - cs and sclk synchroniser flops reset to 0; the mosi flops reset to 0.
  - cs_fall, cs_rise, sclk_rise and sclk_fall are single-cycle pulses.
- **FSM states:** IDLE and SHIFT.
  - IDLE to SHIFT on cs_fall.
  - SHIFT to IDLE on cs_rise.
  - A cs_rise seen in IDLE is ignored.
- **On cs_fall:**
  - bit counter cleared;
  - if send_val=1: tx shift register loaded with send_msg and send_rdy=1 for that one cycle;
  - otherwise tx register loaded with all zeros and send_rdy stays 0.
- **In SHIFT, on sclk_rise:**
  - the synchronised mosi bit is shifted into the LSB of the rx shift register;
  - the counter increments and saturates at BIT_WIDTH+1.
- **In SHIFT, on sclk_fall:** the tx register shifts left by 1 with zero fill.
- **miso** is always the tx register MSB, and is 0 in IDLE.
- **On cs_rise with count == BIT_WIDTH:** the rx register is written into the output buffer and recv_val=1.
  - If the buffer already holds an unaccepted frame (recv_val=1, recv_rdy=0), the new frame is dropped and overflow sets. Overflow stays set until reset.
  - If recv_rdy=1 in that same cycle, the old frame transfers and the new one loads. recv_val stays 1 and no overflow.
- **On cs_rise with count != BIT_WIDTH:** the frame is discarded silently; no overflow.
- **Output buffer:** recv_val clears on the cycle after the recv_val && recv_rdy handshake, unless it is reloaded in that cycle.
- **Reset values:** recv_val=0, recv_msg=0, send_rdy=0, miso=0, overflow=0, parity=0; FSM in IDLE.
- **Reset mid-frame:** the partial frame is lost.
  - If cs is held low across reset release, no cs_fall is detected, so no frame starts until cs goes high and then low again.

## Timing
- Each pin takes 3 clk cycles from pin edge to its edge pulse.
- clk must be at least 8× sclk. sclk high and low phases must each be at least 4 clk cycles.
- recv_val rises 4 clk cycles after the cs rising pin edge.
- send_rdy pulses 3 cycles after the cs falling pin edge.
  - The host must allow at least 6 clk cycles from cs low to the first sclk rise, so that the MSB is on miso.
- After each sclk falling pin edge, miso changes 4 cycles later.
- recv_msg is stable while recv_val=1.

## Configuration
- Macro: SPI_MINION_FRONTEND_PARITY_EN.
- **Defined:** parity = XOR reduction of the output buffer while recv_val=1, registered together with the buffer; parity=0 when recv_val=0.
- **Undefined:** parity is tied to 0 and no parity logic is generated.

## Structure
- **Shared package `spi_minion_pkg`:**
  - FSM state enum (IDLE, SHIFT);
  - counter-width function $clog2(BIT_WIDTH+2);
  - synchroniser depth constant (2).
- **Sub-module `spi_minion_sync_edge`:** one 2-flop synchroniser plus edge detector, instantiated 3×. It outputs the synchronised level, rise and fall.
- All other logic stays in the top module.

## Test plan
- **Single receive.** BIT_WIDTH=8, recv_rdy=1, host sends 0xA5 at clk/8.
  - recv_msg=0xA5, recv_val high 1 cycle, parity=0 with macro.
- **Send and receive in one frame.** send_val=1, send_msg=0x3C, host sends 0x81.
  - miso bit sequence is 0,0,1,1,1,1,0,0; send_rdy is a single pulse.
  - recv_msg=0x81, parity=0 (0 when compiled out).
- **Backpressure overflow.** recv_rdy=0, two frames 0x11 then 0x22.
  - recv_msg stays 0x11 and overflow=1.
  - After recv_rdy=1 and a third frame 0x33: recv_msg=0x33 and overflow remains 1.
- **Short frame.** A 7-bit frame, then an 8-bit 0x5A.
  - No recv_val for the first frame; recv_msg=0x5A for the second; overflow=0.
- **Reset mid-frame.** reset low after 4 bits with cs held low, then released.
  - All outputs are 0.
  - No recv_val until cs goes high, then a full 0xF0 frame yields recv_msg=0xF0.
- **Empty send.** send_val=0 for one frame.
  - miso=0 for all 8 bits; send_rdy never asserts.
